rtc_arb: RTL

- Sits between the 68k bus decode and the DS12887 RTC controller, and is the sole master of that controller's strobe interface.
- Shares the controller between two requesters: the CPU, and an internal periodic poller.
- The poller takes a coherent {hours, minutes, seconds} snapshot from the RTC, honouring the UIP bit, so software and other logic can read the time without touching the RTC.
- CPU has priority at transaction boundaries. An in-flight transaction is never preempted.

---
 rtl/rtc_arb.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_arb.sv
// rtc_arb: sole master of the DS12887 controller strobe interface, sharing it
// between the CPU and a periodic poller that keeps a coherent hh:mm:ss snapshot.
module rtc_arb #(
    parameter int unsigned POLL_DIV = 50000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  cpu_addrbus,
    input  logic [15:0] cpu_datain,
    input  logic        cpu_rdh_n,
    input  logic        cpu_rdl_n,
    input  logic        cpu_wrh_n,
    input  logic        cpu_wrl_n,
    output logic [15:0] cpu_dataout,
    output logic        cpu_dtack_n,
    output logic [5:0]  rtc_addr,
    output logic [15:0] rtc_wdata,
    output logic        rtc_rdh_n,
    output logic        rtc_rdl_n,
    output logic        rtc_wrh_n,
    output logic        rtc_wrl_n,
    input  logic [15:0] rtc_rdata,
    input  logic        rtc_dtack_n,
    input  logic        poll_en,
    output logic [7:0]  snap_sec,
    output logic [7:0]  snap_min,
    output logic [7:0]  snap_hour,
    output logic        snap_valid,
    output logic        snap_busy
);
    localparam int unsigned STRB_W = 4;
    localparam logic [STRB_W-1:0] STRB_IDLE = 4'b1111;
    localparam logic [STRB_W-1:0] STRB_POLL = 4'b0111;  // rdh only: even register on the high byte

    typedef enum logic [2:0] {IDLE, CPU_ACT, CPU_REL, P_ACT, P_REL} state_t;
    typedef enum logic [1:0] {STEP_UIP, STEP_SEC, STEP_MIN, STEP_HOUR} step_t;

    state_t            state, state_d;
    step_t             step, step_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              pend_tick, pend_tick_d;
    logic              snap_busy_d;
    logic [7:0]        shadow_sec, shadow_sec_d;
    logic [7:0]        shadow_min, shadow_min_d;
    logic [15:0]       cpu_dataout_d;
    logic              cpu_dtack_n_d;
    logic [5:0]        rtc_addr_d;
    logic [15:0]       rtc_wdata_d;
    logic [STRB_W-1:0] rtc_strb_d;
    logic [7:0]        snap_sec_d, snap_min_d, snap_hour_d;
    logic              snap_valid_d;

    logic [STRB_W-1:0] cpu_strb;
    logic              cpu_req, cpu_wr, wrap, tick;
    logic [5:0]        step_addr;

    assign cpu_strb = {cpu_rdh_n, cpu_rdl_n, cpu_wrh_n, cpu_wrl_n};
    assign cpu_req  = (cpu_strb != STRB_IDLE);
    assign cpu_wr   = ~(cpu_wrh_n & cpu_wrl_n);
    assign wrap     = (cnt == CNT_W'(POLL_DIV - 1));
    assign tick     = wrap & poll_en;

    // Word address of the register read by the current poller step
    always_comb begin
        case (step)
            STEP_UIP:  step_addr = 6'd5;
            STEP_SEC:  step_addr = 6'd0;
            STEP_MIN:  step_addr = 6'd1;
            default:   step_addr = 6'd2;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state;
        step_d        = step;
        cnt_d         = wrap ? '0 : cnt + CNT_W'(1);
        pend_tick_d   = pend_tick;
        snap_busy_d   = snap_busy;
        shadow_sec_d  = shadow_sec;
        shadow_min_d  = shadow_min;
        cpu_dataout_d = cpu_dataout;
        cpu_dtack_n_d = cpu_dtack_n;
        rtc_addr_d    = rtc_addr;
        rtc_wdata_d   = rtc_wdata;
        rtc_strb_d    = {rtc_rdh_n, rtc_rdl_n, rtc_wrh_n, rtc_wrl_n};
        snap_sec_d    = snap_sec;
        snap_min_d    = snap_min;
        snap_hour_d   = snap_hour;
        snap_valid_d  = 1'b0;

        // A tick during a sequence is remembered once, not queued
        if (!poll_en) begin
            pend_tick_d = 1'b0;
        end else if ((tick || pend_tick) && !snap_busy) begin
            snap_busy_d = 1'b1;
            pend_tick_d = 1'b0;
        end else if (tick) begin
            pend_tick_d = 1'b1;
        end

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_d     = CPU_ACT;
                    rtc_addr_d  = cpu_addrbus;
                    rtc_wdata_d = cpu_datain;
                    rtc_strb_d  = cpu_strb;
                    // A CPU write could tear the snapshot, so start it over
                    if (cpu_wr && snap_busy) begin
                        step_d       = STEP_UIP;
                        shadow_sec_d = 8'h00;
                        shadow_min_d = 8'h00;
                    end
                end else if (snap_busy) begin
                    state_d    = P_ACT;
                    rtc_addr_d = step_addr;
                    rtc_strb_d = STRB_POLL;
                end
            end
            CPU_ACT: begin
                if (!rtc_dtack_n && cpu_dtack_n) begin
                    cpu_dataout_d = rtc_rdata;
                    cpu_dtack_n_d = 1'b0;
                end else if (!cpu_dtack_n && !cpu_req) begin
                    rtc_strb_d    = STRB_IDLE;
                    cpu_dtack_n_d = 1'b1;
                    state_d       = CPU_REL;
                end
            end
            P_ACT: begin
                if (!rtc_dtack_n) begin
                    rtc_strb_d = STRB_IDLE;
                    state_d    = P_REL;
                    case (step)
                        STEP_UIP: begin
                            if (!rtc_rdata[15]) step_d = STEP_SEC;
                        end
                        STEP_SEC: begin
                            shadow_sec_d = rtc_rdata[15:8];
                            step_d       = STEP_MIN;
                        end
                        STEP_MIN: begin
                            shadow_min_d = rtc_rdata[15:8];
                            step_d       = STEP_HOUR;
                        end
                        default: begin
                            snap_sec_d   = shadow_sec;
                            snap_min_d   = shadow_min;
                            snap_hour_d  = rtc_rdata[15:8];
                            snap_valid_d = 1'b1;
                            snap_busy_d  = 1'b0;
                            step_d       = STEP_UIP;
                        end
                    endcase
                end
            end
            CPU_REL, P_REL: begin
                if (rtc_dtack_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step        <= STEP_UIP;
            cnt         <= '0;
            pend_tick   <= 1'b0;
            snap_busy   <= 1'b0;
            shadow_sec  <= 8'h00;
            shadow_min  <= 8'h00;
            cpu_dataout <= 16'h0000;
            cpu_dtack_n <= 1'b1;
            rtc_addr    <= 6'd0;
            rtc_wdata   <= 16'h0000;
            {rtc_rdh_n, rtc_rdl_n, rtc_wrh_n, rtc_wrl_n} <= STRB_IDLE;
            snap_sec    <= 8'h00;
            snap_min    <= 8'h00;
            snap_hour   <= 8'h00;
            snap_valid  <= 1'b0;
        end else begin
            state       <= state_d;
            step        <= step_d;
            cnt         <= cnt_d;
            pend_tick   <= pend_tick_d;
            snap_busy   <= snap_busy_d;
            shadow_sec  <= shadow_sec_d;
            shadow_min  <= shadow_min_d;
            cpu_dataout <= cpu_dataout_d;
            cpu_dtack_n <= cpu_dtack_n_d;
            rtc_addr    <= rtc_addr_d;
            rtc_wdata   <= rtc_wdata_d;
            {rtc_rdh_n, rtc_rdl_n, rtc_wrh_n, rtc_wrl_n} <= rtc_strb_d;
            snap_sec    <= snap_sec_d;
            snap_min    <= snap_min_d;
            snap_hour   <= snap_hour_d;
            snap_valid  <= snap_valid_d;
        end
    end

endmodule
